// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf_pkg
// Brief    : Shared hold-code and payload definitions for pipeline buffers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_buf_pkg;

    localparam int HOLD_CODE_W    = 3;
    localparam int IDEX_PAYLOAD_W = 64;

    typedef logic [HOLD_CODE_W-1:0]    hold_code_t;
    typedef logic [IDEX_PAYLOAD_W-1:0] idex_payload_t;

    // Hold level at which the decode/execute boundary stalls.
    localparam hold_code_t HOLD_CODE_ID = 3'd2;

    // Pointer width that stays at least one bit for a single-entry buffer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_buf_mem.sv
`default_nettype none
// ============================================================================
// Module   : pipe_buf_mem
// Brief    : DEPTH x DATA_W register array, one write port, async read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_buf_mem
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int AW     = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Parametrised valid/ready pipeline buffer with bypass, flush and
//            hold-code stalling; counts beats discarded by flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter int BYPASS   = 0,
    parameter int HOLD_LVL = int'(HOLD_CODE_ID),
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  hold_code_t               hold_code,
    input  logic                     flush_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         kill_cnt_o
);

    localparam int c_cw    = $clog2(DEPTH) + 1;
    localparam int c_aw    = ptr_width(DEPTH);
    localparam int c_sum_w = ((CNT_W > c_cw) ? CNT_W : c_cw) + 1;

    localparam logic [c_cw-1:0]  c_depth    = c_cw'(DEPTH);
    localparam logic [c_aw-1:0]  c_ptr_last = c_aw'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_kill_max = {CNT_W{1'b1}};
    localparam logic             c_bypass   = (BYPASS != 0);

    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_cw-1:0]    r_count;
    logic [CNT_W-1:0]   r_kill_cnt;

    logic               w_stall;
    logic               w_empty;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_bypass_beat;
    logic               w_push;
    logic               w_pop;
    logic               w_in_beat;
    logic [DATA_W-1:0]  w_mem_rdata;
    logic [DATA_W-1:0]  w_out_data;
    logic [c_sum_w-1:0] w_kill_sum;
    logic [CNT_W-1:0]   w_kill_next;

    function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign w_stall     = (int'(hold_code) >= HOLD_LVL);
    assign w_empty     = (r_count == '0);
    assign w_in_ready  = ~rst & (r_count != c_depth);
    assign w_out_valid = ~rst & ~w_stall & ~flush_i & (~w_empty | (c_bypass & in_valid));

    // An empty bypassing buffer hands the beat straight through; nothing is stored.
    assign w_bypass_beat = c_bypass & w_empty & in_valid & out_ready & ~w_stall
                         & ~flush_i & ~rst;
    assign w_push        = in_valid & w_in_ready & ~flush_i & ~w_bypass_beat;
    assign w_pop         = w_out_valid & out_ready & ~w_empty;
    assign w_in_beat     = in_valid & w_in_ready;

    assign w_kill_sum  = c_sum_w'(r_kill_cnt) + c_sum_w'(r_count) + c_sum_w'(w_in_beat);
    assign w_kill_next = (w_kill_sum > c_sum_w'(c_kill_max)) ? c_kill_max
                                                             : w_kill_sum[CNT_W-1:0];

    always_comb begin
        w_out_data = '0;
        if (!rst) begin
            if (!w_empty) begin
                w_out_data = w_mem_rdata;
            end else if (c_bypass) begin
                w_out_data = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_kill_cnt <= '0;
        end else if (flush_i) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_kill_cnt <= w_kill_next;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    pipe_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (c_aw)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = w_out_data;
    assign count_o    = r_count;
    assign kill_cnt_o = r_kill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Self-checking bench: instance 0 without bypass, instance 1 with
//            bypass, both compared every cycle against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;
    import pipe_stage_buf_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int HLVL  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    hold_code_t      hold [2];
    logic            flush[2];
    logic            iv   [2];
    logic            ordy [2];
    logic [DW-1:0]   din  [2];
    logic            ir   [2];
    logic            ov   [2];
    logic [DW-1:0]   dout [2];
    logic [CW-1:0]   cnt  [2];
    logic [3:0]      kill_a;
    logic [7:0]      kill_b;

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(0), .HOLD_LVL(HLVL), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .hold_code(hold[0]), .flush_i(flush[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]),
        .count_o(cnt[0]), .kill_cnt_o(kill_a)
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(DEPTH), .BYPASS(1), .HOLD_LVL(HLVL), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .hold_code(hold[1]), .flush_i(flush[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]),
        .count_o(cnt[1]), .kill_cnt_o(kill_b)
    );

    // Reference model: an ordered list of stored payloads plus a kill tally.
    typedef logic [DW-1:0] q_t[$];
    q_t mq[2];
    int mkill[2];
    int kmax [2] = '{15, 255};
    int byp  [2] = '{0, 1};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          rst, flush, iv, ordy;
        logic [2:0]    hold;
        logic [DW-1:0] din;
        logic          e_ir, e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_cnt;
        logic [3:0]    e_kill;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic r, f, v, o, input logic [2:0] h, input logic [DW-1:0] d,
                                input logic eir, eov, input logic [DW-1:0] eod,
                                input logic [CW-1:0] ec, input logic [3:0] ek);
        vec_t t;
        t.rst = r; t.flush = f; t.iv = v; t.ordy = o; t.hold = h; t.din = d;
        t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_cnt = ec; t.e_kill = ek;
        return t;
    endfunction

    task automatic check(input string name, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int kill_of(input int k);
        return (k == 0) ? int'(kill_a) : int'(kill_b);
    endfunction

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int sz;
            int e_ir, e_ov, e_od;
            bit stall;
            sz    = mq[k].size();
            stall = (int'(hold[k]) >= HLVL);
            e_ir  = (!rst && sz < DEPTH) ? 1 : 0;
            e_ov  = (!rst && !stall && !flush[k] && (sz > 0 || (byp[k] != 0 && iv[k]))) ? 1 : 0;
            if (rst)              e_od = 0;
            else if (sz > 0)      e_od = int'(mq[k][0]);
            else if (byp[k] != 0) e_od = int'(din[k]);
            else                  e_od = 0;
            check("in_ready",  k, int'(ir[k]),   e_ir);
            check("out_valid", k, int'(ov[k]),   e_ov);
            check("out_data",  k, int'(dout[k]), e_od);
            check("count",     k, int'(cnt[k]),  sz);
            check("kill_cnt",  k, kill_of(k),    mkill[k]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int sz;
            bit stall, acc, pop;
            sz    = mq[k].size();
            stall = (int'(hold[k]) >= HLVL);
            acc   = iv[k] && (sz < DEPTH);
            if (rst) begin
                mq[k].delete();
                mkill[k] = 0;
            end else if (flush[k]) begin
                mkill[k] = mkill[k] + sz + (acc ? 1 : 0);
                if (mkill[k] > kmax[k]) mkill[k] = kmax[k];
                mq[k].delete();
            end else if (!(byp[k] != 0 && sz == 0 && iv[k] && ordy[k] && !stall)) begin
                pop = !stall && ordy[k] && (sz > 0);
                if (pop) void'(mq[k].pop_front());
                if (acc) mq[k].push_back(din[k]);
            end
        end
    endtask

    task automatic settle();
        #4;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic drive(input int k, input logic v, input logic [DW-1:0] d, input logic o,
                         input int h, input logic f);
        iv[k] = v; din[k] = d; ordy[k] = o; hold[k] = hold_code_t'(h); flush[k] = f;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin mq[k].delete(); mkill[k] = 0; end

        //            rst fl iv or hold din     ir ov od      cnt kill
        tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,  0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 16'hA1,   1, 0, 16'h0,  0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 16'h0,    1, 1, 16'hA1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 16'h0,    1, 0, 16'h0,  0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 16'h1,    1, 0, 16'h0,  0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 16'h2,    1, 1, 16'h1,  1, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 16'h3,    1, 1, 16'h1,  2, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 16'h4,    1, 1, 16'h1,  3, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 16'h5,    0, 1, 16'h1,  4, 0);
        tbl[9]  = mk(0, 0, 1, 1, 0, 16'h5,    0, 1, 16'h1,  4, 0);
        tbl[10] = mk(0, 0, 1, 1, 0, 16'h5,    1, 1, 16'h2,  3, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 16'h0,    1, 1, 16'h3,  3, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 16'h0,    1, 1, 16'h4,  2, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 16'h0,    1, 1, 16'h5,  1, 0);
        tbl[14] = mk(0, 0, 0, 1, 0, 16'h0,    1, 0, 16'h0,  0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 16'h11,   1, 0, 16'h0,  0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 16'h12,   1, 1, 16'h11, 1, 0);
        tbl[17] = mk(0, 0, 1, 0, 0, 16'h13,   1, 1, 16'h11, 2, 0);
        tbl[18] = mk(0, 1, 1, 0, 0, 16'h14,   1, 0, 16'h11, 3, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 16'h0,    1, 0, 16'h0,  0, 4);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst;
            drive(0, tbl[i].iv, tbl[i].din, tbl[i].ordy, int'(tbl[i].hold), tbl[i].flush);
            settle();
            check("tbl_in_ready",  i, int'(ir[0]),   int'(tbl[i].e_ir));
            check("tbl_out_valid", i, int'(ov[0]),   int'(tbl[i].e_ov));
            check("tbl_out_data",  i, int'(dout[0]), int'(tbl[i].e_od));
            check("tbl_count",     i, int'(cnt[0]),  int'(tbl[i].e_cnt));
            check("tbl_kill",      i, int'(kill_a),  int'(tbl[i].e_kill));
            adv();
        end
        idle_all();

        // Push and pop together at count 3, rotating the pointers many times.
        for (int i = 0; i < 3; i++) begin drive(0, 1'b1, DW'(16'h30 + i), 1'b0, 0, 1'b0); step(); end
        for (int i = 0; i < 10; i++) begin drive(0, 1'b1, DW'(16'h40 + i), 1'b1, 0, 1'b0); step(); end
        drive(0, 1'b0, '0, 1'b0, 0, 1'b0);
        settle();
        check("rot_count", 0, int'(cnt[0]),  3);
        check("rot_head",  0, int'(dout[0]), 'h47);
        adv();
        for (int i = 0; i < 3; i++) begin drive(0, 1'b0, '0, 1'b1, 0, 1'b0); step(); end

        // Stall with two entries: nothing drains, a push still lands.
        for (int i = 0; i < 2; i++) begin drive(0, 1'b1, DW'(16'h50 + i), 1'b0, 0, 1'b0); step(); end
        for (int i = 0; i < 3; i++) begin drive(0, 1'b0, '0, 1'b1, HLVL, 1'b0); step(); end
        drive(0, 1'b1, 16'h52, 1'b1, HLVL, 1'b0); step();
        drive(0, 1'b0, '0, 1'b1, HLVL, 1'b0);
        settle();
        check("stall_count", 0, int'(cnt[0]), 3);
        check("stall_valid", 0, int'(ov[0]),  0);
        adv();
        for (int i = 0; i < 4; i++) begin drive(0, 1'b0, '0, 1'b1, 0, 1'b0); step(); end

        // Repeated flushes of 3 stored + 1 incoming beat until the counter saturates.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin drive(0, 1'b1, DW'(16'h60 + i), 1'b0, 0, 1'b0); step(); end
            drive(0, 1'b1, 16'h6F, 1'b0, (r == 3) ? HLVL : 0, 1'b1); step();
        end
        drive(0, 1'b0, '0, 1'b0, 0, 1'b0);
        settle();
        check("kill_sat",   0, int'(kill_a), 15);
        check("kill_count", 0, int'(cnt[0]), 0);
        adv();

        // Bypass instance: zero-latency pass-through when empty.
        drive(1, 1'b1, 16'h55, 1'b1, 0, 1'b0);
        settle();
        check("byp_valid", 1, int'(ov[1]),   1);
        check("byp_data",  1, int'(dout[1]), 'h55);
        check("byp_count", 1, int'(cnt[1]),  0);
        adv();
        for (int i = 0; i < 2; i++) begin drive(1, 1'b1, DW'(16'h70 + i), 1'b0, 0, 1'b0); step(); end
        drive(1, 1'b0, '0, 1'b0, 0, 1'b1); step();
        for (int i = 0; i < 2; i++) begin drive(1, 1'b1, DW'(16'h78 + i), 1'b0, 0, 1'b0); step(); end
        rst = 1'b1;
        drive(1, 1'b1, 16'h7A, 1'b1, 0, 1'b0);
        settle();
        check("rst_in_ready",  1, int'(ir[1]),   0);
        check("rst_out_valid", 1, int'(ov[1]),   0);
        check("rst_out_data",  1, int'(dout[1]), 0);
        adv();
        rst = 1'b0;
        drive(1, 1'b0, '0, 1'b0, 0, 1'b0);
        settle();
        check("post_rst_count", 1, int'(cnt[1]), 0);
        check("post_rst_kill",  1, int'(kill_b), 0);
        check("post_rst_ready", 1, int'(ir[1]),  1);
        adv();

        // Randomised traffic on both instances.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                int h;
                h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
                drive(k, ($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 6),
                      h, ($urandom_range(0, 15) == 0));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
